pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-width inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control word and one data bundle per entry.
- Adds valid/ready handshaking, a 2-entry skid buffer for full throughput with registered in_ready, hold (stall), flush (bubble insertion) and a saturating bubble counter.
- Instantiated between any two stages; width set per instance.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_sat_counter.sv | 29 ++
 rtl/pipe_stage_skid.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : pipe_pkg                                                   |
// | Purpose   : Shared definitions for the skid-buffered pipeline stage:   |
// |             occupancy state encoding and the bubble control value.     |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
package pipe_pkg;

  // The state value is the number of entries held, so it doubles as the
  // occupancy output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Replicated to CTRL_W bits at the use site: an all-zero control word
  // decodes as a NOP in every downstream stage.
  localparam bit CTRL_BUBBLE = 1'b0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : pipe_sat_counter                                           |
// | Purpose   : Up-counter that sticks at all-ones instead of wrapping.    |
// | Ports     : clk   - clock, rising edge                                 |
// |             reset - asynchronous active-high reset, clears count       |
// |             inc   - count this cycle                                   |
// |             count - current value                                      |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : pipe_stage_skid                                            |
// | Purpose   : Inter-stage pipeline register with valid/ready handshake,  |
// |             2-entry skid buffer (registered in_ready, full rate),      |
// |             hold (stall), flush (squash) and a saturating count of     |
// |             bubble cycles.                                             |
// | Ports     : clk, reset      - clock / async active-high reset          |
// |             in_valid/ready  - upstream handshake                       |
// |             in_ctrl/in_data - upstream control word / data bundle      |
// |             hold, flush     - stall / squash all held entries          |
// |             out_valid/ready - downstream handshake                     |
// |             out_ctrl        - control word, zero when no entry         |
// |             out_data        - data bundle, stale when no entry         |
// |             occupancy       - entries held (0..2)                      |
// |             bubble_cnt      - cycles with out_valid low, saturating    |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_t            state;
  state_t            state_next;
  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid_in;

  // Entry valids are implied by occupancy: main is filled first and the
  // skid slot only ever holds the younger of two entries.
  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);

  // in_ready depends only on registered state (plus hold), never on
  // out_ready, which breaks the combinational ready chain between stages.
  assign in_ready  = !skid_valid && !hold;
  assign out_valid = main_valid && !hold;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      // Squash takes priority even over an accepted input: the entry is lost.
      state_next = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next   = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_next   = ST_FULL;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_next     = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (load_main_in) begin
      main_ctrl <= in_ctrl;
      main_data <= in_data;
    end else if (load_main_skid) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (load_skid_in) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  // An empty stage presents a NOP control word even while held.
  assign out_ctrl  = main_valid ? main_ctrl : {CTRL_W{CTRL_BUBBLE}};
  assign out_data  = main_data;
  assign occupancy = state;

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!out_valid),
    .count (bubble_cnt)
  );

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : tb_pipe_stage_skid                                         |
// | Purpose   : Self-checking bench for pipe_stage_skid. A queue model of  |
// |             a depth-2 FIFO is compared against the DUT every cycle;    |
// |             directed phases pin the model with literal values.        |
// | Revision  : 1.0 - initial release                                      |
// +------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int CW = 22;
  localparam int DW = 128;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt;

  // Second instance: narrow counter, never fed, to reach saturation quickly.
  logic          s_in_ready;
  logic          s_out_valid;
  logic [3:0]    s_out_ctrl;
  logic [7:0]    s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_cnt;

  int checks = 0;
  int errors = 0;

  logic [CW+DW-1:0] q[$];
  int unsigned      m_cnt  = 0;
  int unsigned      m_cnt4 = 0;
  bit               mon9 = 1'b0;
  bit               saw9 = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_data    (in_data),
    .hold       (hold),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(.CTRL_W(4), .DATA_W(8), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (1'b0),
    .in_ready   (s_in_ready),
    .in_ctrl    (4'h0),
    .in_data    (8'h00),
    .hold       (1'b0),
    .flush      (1'b0),
    .out_valid  (s_out_valid),
    .out_ready  (1'b0),
    .out_ctrl   (s_out_ctrl),
    .out_data   (s_out_data),
    .occupancy  (s_occupancy),
    .bubble_cnt (s_cnt)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue of at most two entries. Outputs are
  // derived from the queue contents as they stand before each edge.
  initial begin
    bit rdy;
    bit vld;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
        m_cnt  = 0;
        m_cnt4 = 0;
      end else begin
        rdy = (q.size() < 2) && !hold;
        vld = (q.size() > 0) && !hold;
        if (!vld && m_cnt != 32'hFFFF) m_cnt++;
        if (m_cnt4 != 15) m_cnt4++;
        if (flush) begin
          q.delete();
        end else begin
          if (vld && out_ready) void'(q.pop_front());
          if (in_valid && rdy) q.push_back({in_ctrl, in_data});
        end
      end
    end
  end

  task automatic compare();
    logic [CW+DW-1:0] h;
    logic [CW-1:0]    ec;
    h  = '0;
    ec = '0;
    if (q.size() > 0) begin
      h  = q[0];
      ec = h[CW+DW-1:DW];
    end
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, (q.size() < 2) && !hold);
    chk("out_valid", out_valid, (q.size() > 0) && !hold);
    chk("out_ctrl", out_ctrl, ec);
    if (q.size() > 0) chk("out_data", out_data, h[DW-1:0]);
    chk("bubble_cnt", bubble_cnt, m_cnt);
    chk("sat_cnt", s_cnt, m_cnt4);
    chk("sat_valid", s_out_valid, 1'b0);
    if (mon9 && out_valid && out_data == 9) saw9 = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [NW-1:0] c0;
    logic [NW-1:0] c1;

    tick();
    tick();
    reset = 1'b0;

    // Reset mid-stream from FULL
    in_ctrl  = 22'h3A5A5A;
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data  = 1;
    tick();
    in_data  = 2;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_occ", occupancy, 2'd2);
    chk("pre_reset_ctrl", out_ctrl, 22'h3A5A5A);
    #1 reset = 1'b1;
    #1;
    chk("rst_occ", occupancy, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_ctrl", out_ctrl, 22'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bubble", bubble_cnt, 16'h0);
    tick();
    reset = 1'b0;

    // Streaming at full rate
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      in_ctrl = CW'($urandom);
      tick();
      chk("stream_data", out_data, i);
      chk("stream_occ", occupancy, 2'd1);
      chk("stream_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain", occupancy, 2'd0);

    // Backpressure fills the skid slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 1;
    tick();
    in_data   = 2;
    tick();
    in_valid  = 1'b0;
    chk("bp_occ", occupancy, 2'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    #1 chk("bp_first", out_data, 1);
    tick();
    chk("bp_second", out_data, 2);
    chk("bp_ready_back", in_ready, 1'b1);
    tick();
    chk("bp_empty", occupancy, 2'd0);
    out_ready = 1'b0;

    // Hold for three cycles
    in_valid = 1'b1;
    in_data  = 5;
    tick();
    in_valid = 1'b0;
    hold     = 1'b1;
    #1;
    c0 = bubble_cnt;
    chk("hold_out_valid", out_valid, 1'b0);
    chk("hold_in_ready", in_ready, 1'b0);
    tick();
    tick();
    tick();
    c1 = bubble_cnt;
    chk("hold_bubble_delta", c1 - c0, 16'd3);
    chk("hold_data", out_data, 5);
    chk("hold_occ", occupancy, 2'd1);
    hold = 1'b0;
    #1 chk("hold_release", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("hold_issued", occupancy, 2'd0);
    out_ready = 1'b0;

    // Flush from FULL with an offered input, then flush beating an accept
    mon9     = 1'b1;
    in_valid = 1'b1;
    in_data  = 7;
    tick();
    in_data  = 8;
    tick();
    chk("flush_full", occupancy, 2'd2);
    in_data  = 9;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", occupancy, 2'd0);
    chk("flush_ctrl", out_ctrl, 22'h0);
    chk("flush_valid", out_valid, 1'b0);
    in_valid = 1'b1;
    in_data  = 7;
    tick();
    in_data  = 9;
    flush    = 1'b1;
    chk("flush_accepting", in_ready, 1'b1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_drop_occ", occupancy, 2'd0);
    out_ready = 1'b1;
    repeat (4) tick();
    mon9 = 1'b0;
    chk("flush_no9", saw9, 1'b0);

    // Randomized traffic including hold, flush and one asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      hold      = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      if (n == 1500) begin
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    hold      = 1'b0;
    flush     = 1'b0;
    repeat (25) tick();
    chk("sat_final", s_cnt, 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire
